// File: rtl/card_rom_arbiter.sv
// card_rom_arbiter
// Round-robin arbiter that lets NUM_REQ card-drawing requesters share one
// synchronous card image ROM. One request is accepted per cycle; the granted
// suit/address is registered toward the ROM, and a one-hot owner tag travels
// through a two-stage pipeline so the ROM data that comes back is flagged for
// the requester that asked for it.
//
// Ports
//   clk_i        clock, all logic on the rising edge
//   rst_ni       asynchronous active-low reset
//   req_valid_i  [NUM_REQ]             per-requester read request
//   req_suit_i   [NUM_REQ*2]           per-requester suit, slice i = [2i+1:2i]
//   req_addr_i   [NUM_REQ*ADDR_WIDTH]  per-requester pixel address
//   req_ready_o  [NUM_REQ]             one-hot grant (combinational)
//   rom_suit_o   [2]                   registered suit index to the ROM
//   rom_addr_o   [ADDR_WIDTH]          registered address to the ROM
//   rom_dout_i   [DATA_WIDTH]          ROM data, one cycle after suit/addr
//   rsp_valid_o  [NUM_REQ]             one-hot owner of rsp_data_o
//   rsp_data_o   [DATA_WIDTH]          returned pixel
module card_rom_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 12
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*2-1:0]          req_suit_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [1:0]                    rom_suit_o,
    output logic [ADDR_WIDTH-1:0]         rom_addr_o,
    input  logic [DATA_WIDTH-1:0]         rom_dout_i,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    output logic [DATA_WIDTH-1:0]         rsp_data_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [1:0]            rom_suit_q, rom_suit_d;
    logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic [NUM_REQ-1:0]    tag1_q, tag1_d;
    logic [NUM_REQ-1:0]    tag2_q;

    logic [NUM_REQ-1:0]    grant;
    logic [PTR_W-1:0]      gnt_idx;
    logic                  gnt_any;

    logic [1:0]            suit_arr [NUM_REQ];
    logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            suit_arr[i] = req_suit_i[2*i +: 2];
            addr_arr[i] = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    // Scan from ptr upward, wrapping; the first valid requester wins.
    always_comb begin
        logic [PTR_W:0] scan;
        gnt_any = 1'b0;
        gnt_idx = '0;
        scan    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (scan >= (PTR_W+1)'(NUM_REQ)) begin
                scan = scan - (PTR_W+1)'(NUM_REQ);
            end
            if (!gnt_any && req_valid_i[scan[PTR_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = scan[PTR_W-1:0];
            end
        end
        grant = gnt_any ? (NUM_REQ'(1) << gnt_idx) : '0;
    end

    always_comb begin
        ptr_d      = ptr_q;
        rom_suit_d = rom_suit_q;
        rom_addr_d = rom_addr_q;
        tag1_d     = '0;
        if (gnt_any) begin
            ptr_d      = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            rom_suit_d = suit_arr[gnt_idx];
            rom_addr_d = addr_arr[gnt_idx];
            tag1_d     = grant;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q      <= '0;
            rom_suit_q <= '0;
            rom_addr_q <= '0;
            tag1_q     <= '0;
            tag2_q     <= '0;
        end else begin
            ptr_q      <= ptr_d;
            rom_suit_q <= rom_suit_d;
            rom_addr_q <= rom_addr_d;
            tag1_q     <= tag1_d;
            tag2_q     <= tag1_q;
        end
    end

    // Grant is masked by reset so nothing is accepted while rst_ni is low.
    assign req_ready_o = rst_ni ? grant : '0;
    assign rom_suit_o  = rom_suit_q;
    assign rom_addr_o  = rom_addr_q;
    assign rsp_valid_o = tag2_q;
    assign rsp_data_o  = rom_dout_i;

endmodule

// File: tb/tb_card_rom_arbiter.sv
module tb_card_rom_arbiter;
    localparam int N  = 4;
    localparam int AW = 11;
    localparam int DW = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid;
    logic [1:0]      suit [N];
    logic [AW-1:0]   addr [N];
    logic [2*N-1:0]  req_suit;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    req_ready;
    logic [1:0]      rom_suit;
    logic [AW-1:0]   rom_addr;
    logic [DW-1:0]   rom_dout;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;

    logic [DW-1:0]   rom_mem [0:(1<<(AW+2))-1];

    card_rom_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_suit_i(req_suit), .req_addr_i(req_addr),
        .req_ready_o(req_ready), .rom_suit_o(rom_suit), .rom_addr_o(rom_addr),
        .rom_dout_i(rom_dout), .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data)
    );

    always_comb begin
        req_suit = '0;
        req_addr = '0;
        for (int i = 0; i < N; i++) begin
            req_suit[2*i +: 2]  = suit[i];
            req_addr[i*AW +: AW] = addr[i];
        end
    end

    // Synchronous ROM: data for the presented suit/address one clock later.
    always @(posedge clk) rom_dout <= rom_mem[{rom_suit, rom_addr}];

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    int            m_ptr;
    logic [1:0]    m_suit;
    logic [AW-1:0] m_addr;
    int            s1_g;
    logic [1:0]    s1_suit;
    logic [AW-1:0] s1_addr;
    logic [N-1:0]  last_rdy;
    int            wait_cnt [N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_suit = '0;
        m_addr = '0;
        s1_g   = -1;
    endtask

    function automatic int model_grant();
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    // One clock of traffic: check the grant, advance, check ROM regs and response.
    task automatic cycle();
        int            g, og;
        logic [1:0]    os;
        logic [AW-1:0] oa;
        logic [N-1:0]  exp_v;
        g = model_grant();
        exp_v = '0;
        if (g >= 0) exp_v = N'(1) << g;
        #1;
        chk("req_ready", req_ready, exp_v);
        last_rdy = req_ready;
        @(posedge clk);
        #1;
        og = s1_g; os = s1_suit; oa = s1_addr;
        if (g >= 0) begin
            m_ptr   = (g + 1) % N;
            m_suit  = suit[g];
            m_addr  = addr[g];
            s1_g    = g;
            s1_suit = suit[g];
            s1_addr = addr[g];
        end else begin
            s1_g = -1;
        end
        exp_v = '0;
        if (og >= 0) exp_v = N'(1) << og;
        chk("rsp_valid", rsp_valid, exp_v);
        if (og >= 0) chk("rsp_data", rsp_data, rom_mem[{os, oa}]);
        chk("rom_suit", rom_suit, m_suit);
        chk("rom_addr", rom_addr, m_addr);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < (1 << (AW+2)); i++) rom_mem[i] = DW'($urandom);
        for (int i = 0; i < N; i++) begin
            suit[i] = '0; addr[i] = '0; wait_cnt[i] = 0;
        end
        model_reset();
        last_rdy = '0;

        // Reset: outputs idle even with every request raised
        req_valid = '1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rom_suit", rom_suit, 0);
        chk("rst_rom_addr", rom_addr, 0);
        req_valid = '0;
        rst_n = 1'b1;
        model_reset();

        // Single requester 2, romb[0x005]
        req_valid = 4'b0100; suit[2] = 2'd3; addr[2] = 11'h005;
        repeat (4) cycle();
        chk("r029_ready", last_rdy, 4'b0100);
        chk("r029_rsp_valid", rsp_valid, 4'b0100);
        chk("r029_rsp_data", rsp_data, rom_mem[{2'd3, 11'h005}]);

        // Drain, then idle for 5 cycles
        req_valid = '0;
        repeat (7) cycle();
        chk("idle_rom_addr", rom_addr, 11'h005);
        chk("idle_rom_suit", rom_suit, 2'd3);

        // All requesters from reset: grants rotate 0,1,2,3,...
        do_reset();
        for (int i = 0; i < N; i++) begin
            suit[i] = 2'($urandom); addr[i] = AW'($urandom);
        end
        req_valid = '1;
        for (int c = 0; c < 8; c++) begin
            cycle();
            chk("r030_grant", last_rdy, 32'(1) << (c % N));
        end

        // Wrap-around: get ptr to 3, then 0 and 3 compete
        req_valid = 4'b0100;
        cycle();
        req_valid = 4'b1001;
        cycle();
        chk("r031_first", last_rdy, 4'b1000);
        cycle();
        chk("r031_second", last_rdy, 4'b0001);
        req_valid = '0;
        repeat (2) cycle();

        // Reset pulse one cycle after an accept flushes the pending response
        req_valid = 4'b0010; addr[1] = 11'h2a5;
        cycle();
        req_valid = '1;
        rst_n = 1'b0;
        #1;
        chk("r033_ready", req_ready, 0);
        chk("r033_rsp_valid", rsp_valid, 0);
        chk("r033_rom_suit", rom_suit, 0);
        chk("r033_rom_addr", rom_addr, 0);
        @(posedge clk);
        #1;
        chk("r033_rsp_t2", rsp_valid, 0);
        @(posedge clk);
        #1;
        chk("r033_rsp_t3", rsp_valid, 0);
        rst_n = 1'b1;
        model_reset();
        cycle();
        chk("r033_first_grant", last_rdy, 4'b0001);
        req_valid = '0;
        repeat (2) cycle();

        // Random traffic: requesters hold until granted, occasionally give up
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                logic granted;
                granted = last_rdy[i] & req_valid[i];
                if (req_valid[i] && !granted) begin
                    if ($urandom_range(15) == 0) req_valid[i] = 1'b0;
                end else if ($urandom_range(1) == 1) begin
                    req_valid[i] = 1'b1;
                    suit[i] = 2'($urandom);
                    addr[i] = AW'($urandom);
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
            cycle();
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && !last_rdy[i]) wait_cnt[i]++;
                else wait_cnt[i] = 0;
                if (req_valid[i]) chk("starve", 32'(wait_cnt[i] <= N - 1), 1);
            end
            last_rdy = last_rdy;
        end
        req_valid = '0;
        repeat (3) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/card_rom_arbiter.md
CARD_ROM_ARBITER -- requirements
Module: card_rom_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of card-drawing requesters sharing one card image ROM.
REQ-002 Parameter ADDR_WIDTH, default 11, ROM word address width per suit image.
REQ-003 Parameter DATA_WIDTH, default 12, RGB pixel width returned by the ROM.
REQ-004 clk  in  1  single clock, all logic posedge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req_valid  in  NUM_REQ  per-requester read request.
REQ-007 req_suit  in  NUM_REQ*2  per-requester suit select (0 trefl, 1 pik, 2 serce, 3 romb), slice i = bits [2i+1:2i].
REQ-008 req_addr  in  NUM_REQ*ADDR_WIDTH  per-requester pixel address, slice i = bits [(i+1)*ADDR_WIDTH-1 : i*ADDR_WIDTH].
REQ-009 req_ready  out  NUM_REQ  one-hot grant; a request is accepted in a cycle where req_valid[i] and req_ready[i] are both 1.
REQ-010 rom_suit  out  2  registered suit index driven to the shared ROM.
REQ-011 rom_addr  out  ADDR_WIDTH  registered address driven to the shared ROM.
REQ-012 rom_dout  in  DATA_WIDTH  ROM read data, valid one clk after rom_suit/rom_addr are presented.
REQ-013 rsp_valid  out  NUM_REQ  one-hot, marks the requester owning rsp_data this cycle.
REQ-014 rsp_data  out  DATA_WIDTH  pixel returned to the requester flagged by rsp_valid.

Function
REQ-015 Arbitration SHALL be round-robin: a priority pointer ptr (0..NUM_REQ-1) names the highest-priority requester; search order ptr, ptr+1, ... wrapping modulo NUM_REQ.
REQ-016 req_ready SHALL be combinational from req_valid and ptr, SHALL be all-zero when no req_valid bit is set, and SHALL never have more than one bit set.
REQ-017 On an accepted request from requester g, ptr SHALL update to (g+1) mod NUM_REQ at that clock edge; with no accepted request, ptr SHALL hold.
REQ-018 At the accept edge, rom_suit/rom_addr SHALL register the granted requester's suit/address, and a one-hot tag of g SHALL enter stage 1 of a 2-stage tag pipeline.
REQ-019 With no accepted request, rom_suit/rom_addr SHALL hold their previous values, and stage 1 SHALL load all-zero.
REQ-020 Tag stage 2 SHALL register stage 1 every cycle; rsp_valid SHALL equal stage 2; rsp_data SHALL equal rom_dout, passed through combinationally.
REQ-021 Latency: a request accepted at edge t SHALL produce rsp_valid at edge t+2, with rsp_data equal to the ROM content at [suit][addr].
REQ-022 Throughput: one accepted request per cycle; responses SHALL return in acceptance order; the arbiter SHALL never stall (no backpressure on responses).
REQ-023 A requester holding req_valid high continuously SHALL be granted at least once every NUM_REQ cycles (no starvation).
REQ-024 A requester SHALL NOT be granted in two consecutive cycles while any other requester has req_valid high.
REQ-025 Requests SHALL NOT be queued: a valid request with req_ready low is not accepted, and the requester holds it.
REQ-026 A request whose req_valid drops before it is granted SHALL be discarded, with no response produced.

Reset
REQ-027 While rst_n=0, ptr=0, rom_suit=0, rom_addr=0, both tag stages=0, rsp_valid=0, req_ready=0 regardless of req_valid.
REQ-028 Assertion of rst_n mid-operation SHALL flush in-flight tags immediately, with no rsp_valid for outstanding requests; after release, the first arbitration SHALL start from ptr=0.

Verification
REQ-029 After reset, single requester 2 holds req_valid with suit=3, addr=0x005 -> req_ready=4'b0100 each cycle; rsp_valid=4'b0100 two cycles after the first accept, with rsp_data = romb[0x005].
REQ-030 All four req_valid held high from reset -> grants 0,1,2,3,0,1,... one per cycle; rsp_valid repeats the same sequence delayed by 2 cycles.
REQ-031 With ptr=3 and requesters 0 and 3 valid -> requester 3 granted, ptr becomes 0, next cycle requester 0 granted (wrap-around).
REQ-032 req_valid=0 for all requesters for 5 cycles -> req_ready=0, rsp_valid=0, rom_addr/rom_suit unchanged, ptr unchanged.
REQ-033 Requester 1 accepted at edge t, rst_n pulsed low at t+1 -> rsp_valid stays 0 at t+2, and every output reads its REQ-027 value while rst_n=0.
REQ-034 Random req_valid traffic on a 4-requester bench, checked against a reference model -> one-hot req_ready, responses match the model data and ordering, and no requester waits more than 4 cycles for a grant.
